// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store.
// Round-robin tie-break, CPU stall generation and a response watchdog.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mcmd_t;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        err
);

  // Counter value one cycle before it would reach TIMEOUT-1.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 2);

  state_t      state;
  state_t      state_nx;
  owner_t      owner;
  owner_t      last_owner;
  owner_t      win;
  logic        store_q;
  logic [7:0]  wd_cnt;
  logic        err_q;

  logic        req_any;
  logic        pick_d;
  logic        grant;
  logic        resp;
  logic        expire;
  logic        done;
  logic [31:0] rsp_data;
  mcmd_t       cmd;

  assign req_any = if_req | d_req;
  assign pick_d  = d_req & (~if_req | (last_owner == OWN_IF));
  assign win     = pick_d ? OWN_D : OWN_IF;

  assign grant  = (state == IDLE) & req_any & ~reset;
  assign resp   = (state == BUSY) & m_rvalid;
  assign expire = (state == BUSY) & ~m_rvalid
                & (wd_cnt == WD_LAST);
  assign done   = (resp | expire) & ~reset;

  assign rsp_data = resp ? m_rdata : ERR_DATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant) state_nx = BUSY;
      BUSY: if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      store_q    <= 1'b0;
      wd_cnt     <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      if (grant) begin
        owner      <= win;
        last_owner <= win;
        store_q    <= (win == OWN_D) & d_we;
        wd_cnt     <= 8'd0;
      end else if (state == BUSY && !m_rvalid) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cmd = '0;
    unique case (1'b1)
      grant & (win == OWN_D): begin
        cmd = '{we: d_we, addr: d_addr,
                wdata: d_wdata, be: d_be};
      end
      grant & (win == OWN_IF): begin
        cmd = '{we: 1'b0, addr: if_addr,
                wdata: 32'h0, be: 4'hF};
      end
      default: cmd = '0;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = 32'h0;
    d_rdata   = 32'h0;
    m_req     = grant;
    {m_we, m_addr, m_wdata, m_be} = cmd;
    if (grant) begin
      if (win == OWN_D) d_gnt  = 1'b1;
      else              if_gnt = 1'b1;
    end
    if (done) begin
      if (owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = store_q ? 32'h0 : rsp_data;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = rsp_data;
      end
    end
  end

  assign stall = (state == BUSY)
               | (d_req & ~d_gnt)
               | (if_req & ~if_gnt);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus corner sequences, with a memory model
// and per-requester response scoreboards.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [31:0] MK = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stall;
  logic        err;

  mem_arbiter #(
    .TIMEOUT (TO),
    .ERR_DATA(ERRD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .stall    (stall),
    .err      (err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  // Memory model: answers each accepted command lat cycles later.
  int          lat = 1;
  bit          mute = 1'b0;
  int          inj_at = -1;
  int          mcnt = 0;
  logic [31:0] mpend = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return a ^ MK;
  endfunction

  initial begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(negedge clk);
      if (m_req === 1'b1 && !mute && reset === 1'b0) begin
        mcnt  = lat;
        mpend = memf(m_addr);
      end
      @(posedge clk);
      #1;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = mpend;
        end
      end
      if (cyc == inj_at) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'h1111_2222;
      end
    end
  end

  logic [31:0] fq[$];
  logic [31:0] dq[$];

  always @(negedge clk) begin
    chk1("gnt_onehot", if_gnt & d_gnt, 1'b0);
    if (if_rvalid === 1'b1) begin
      if (fq.size() == 0) chk1("if_rvalid_unexp", if_rvalid, 1'b0);
      else chk("if_rdata", if_rdata, fq.pop_front());
    end
    if (d_rvalid === 1'b1) begin
      if (dq.size() == 0) chk1("d_rvalid_unexp", d_rvalid, 1'b0);
      else chk("d_rdata", d_rdata, dq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_reqs();
    tick();
    reset = 1'b0;
    fq.delete();
    dq.delete();
  endtask

  task automatic wait_rv(input bit isd, input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      chk1("stall_busy", stall, 1'b1);
      if ((isd ? d_rvalid : if_rvalid) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    bit          isd;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic        xwe;
    logic [3:0]  xbe;
    logic [31:0] xrd;
  } vec_t;

  vec_t vt[5];

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit mlast;
    bit wd;
    vt[0] = '{"fetch_alone", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 2,
              1'b0, 4'hF, 32'h0050_0093};
    vt[1] = '{"load", 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1,
              1'b0, 4'hF, 32'h1357_9ADF};
    vt[2] = '{"store", 1'b1, 1'b1, 32'h204, 32'hA5A5_1234, 4'b0011, 3,
              1'b1, 4'b0011, 32'h0};
    vt[3] = '{"fetch_l3", 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 3,
              1'b0, 4'hF, 32'h1357_9B9B};
    vt[4] = '{"load_hi", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'b1000, 1,
              1'b0, 4'b1000, 32'hECA8_6423};

    reset = 1'b1;
    idle_reqs();
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'({d_gnt, if_gnt}), 32'd0);
    chk("rst_rv", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk1("rst_mreq", m_req, 1'b0);
    chk("rst_mfields", m_addr | m_wdata | 32'({m_we, m_be}), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    tick();
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      lat = vt[k].lat;
      if (vt[k].isd) begin
        d_req   = 1'b1;
        d_we    = vt[k].we;
        d_addr  = vt[k].addr;
        d_wdata = vt[k].wdata;
        d_be    = vt[k].be;
        dq.push_back(vt[k].xrd);
      end else begin
        if_req  = 1'b1;
        if_addr = vt[k].addr;
        fq.push_back(vt[k].xrd);
      end
      @(negedge clk);
      chk({vt[k].name, "_gnt"}, 32'({d_gnt, if_gnt}),
          vt[k].isd ? 32'd2 : 32'd1);
      chk1({vt[k].name, "_mreq"}, m_req, 1'b1);
      chk1({vt[k].name, "_mwe"}, m_we, vt[k].xwe);
      chk({vt[k].name, "_maddr"}, m_addr, vt[k].addr);
      chk({vt[k].name, "_mbe"}, 32'(m_be), 32'(vt[k].xbe));
      if (vt[k].isd)
        chk({vt[k].name, "_mwdata"}, m_wdata, vt[k].wdata);
      tick();
      idle_reqs();
      wait_rv(vt[k].isd, 10, n);
      chk({vt[k].name, "_lat"}, 32'(n), 32'(vt[k].lat));
      tick();
    end

    // Tie right after reset: data first, fetch after the gap cycle.
    do_reset();
    lat = 1;
    if_req = 1'b1;
    if_addr = 32'h48;
    d_req = 1'b1;
    d_addr = 32'h100;
    d_be = 4'hF;
    dq.push_back(32'h1357_9ADF);
    fq.push_back(32'h1357_9B97);
    @(negedge clk);
    chk("tie_c3_gnt", 32'({d_gnt, if_gnt}), 32'd2);
    tick();
    d_req = 1'b0;
    d_addr = '0;
    d_be = '0;
    @(negedge clk);
    chk1("tie_c4_drv", d_rvalid, 1'b1);
    chk1("tie_c4_ifgnt", if_gnt, 1'b0);
    chk1("tie_c4_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    chk("tie_c5_gnt", 32'({d_gnt, if_gnt}), 32'd1);
    tick();
    idle_reqs();
    @(negedge clk);
    chk1("tie_c6_ifrv", if_rvalid, 1'b1);
    tick();

    // Both held for 12 cycles: strict alternation from data.
    do_reset();
    lat = 1;
    if_req = 1'b1;
    if_addr = 32'h300;
    d_req = 1'b1;
    d_addr = 32'h400;
    d_be = 4'hF;
    mlast = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) begin
        wd = !mlast;
        if (wd) dq.push_back(32'h400 ^ MK);
        else    fq.push_back(32'h300 ^ MK);
        @(negedge clk);
        chk("cont_gnt", 32'({d_gnt, if_gnt}), wd ? 32'd2 : 32'd1);
        mlast = wd;
      end else begin
        @(negedge clk);
        chk("cont_gap_gnt", 32'({d_gnt, if_gnt}), 32'd0);
      end
      tick();
    end
    idle_reqs();
    @(negedge clk);
    chk("cont_drain", 32'(fq.size() + dq.size()), 32'd0);
    tick();

    // Watchdog on a fetch, then on a store.
    do_reset();
    mute = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h80;
    fq.push_back(ERRD);
    @(negedge clk);
    chk1("wd_gnt", if_gnt, 1'b1);
    tick();
    idle_reqs();
    wait_rv(1'b0, 12, n);
    chk("wd_lat", 32'(n), 32'(TO - 1));
    chk1("wd_err_pre", err, 1'b0);
    tick();
    @(negedge clk);
    chk1("wd_err_set", err, 1'b1);
    chk1("wd_idle_stall", stall, 1'b0);
    tick();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h208;
    d_wdata = 32'h1234_5678;
    d_be = 4'hF;
    dq.push_back(32'h0);
    @(negedge clk);
    chk1("wd_st_gnt", d_gnt, 1'b1);
    tick();
    idle_reqs();
    wait_rv(1'b1, 12, n);
    chk("wd_st_lat", 32'(n), 32'(TO - 1));
    tick();
    mute = 1'b0;
    lat = 2;
    d_req = 1'b1;
    d_addr = 32'h100;
    d_be = 4'hF;
    dq.push_back(32'h1357_9ADF);
    @(negedge clk);
    chk1("post_wd_gnt", d_gnt, 1'b1);
    tick();
    idle_reqs();
    wait_rv(1'b1, 10, n);
    chk("post_wd_lat", 32'(n), 32'd2);
    chk1("err_sticky", err, 1'b1);
    tick();

    // Spurious response while idle is dropped.
    inj_at = cyc + 1;
    tick();
    @(negedge clk);
    chk("spur_rv", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk1("spur_stall", stall, 1'b0);
    tick();

    // Reset on the second BUSY cycle, late response afterwards.
    mute = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h90;
    @(negedge clk);
    chk1("rm_gnt", if_gnt, 1'b1);
    tick();
    idle_reqs();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rm_rst_rv", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk1("rm_rst_mreq", m_req, 1'b0);
    tick();
    reset = 1'b0;
    inj_at = cyc + 1;
    @(negedge clk);
    chk1("rm_err_clr", err, 1'b0);
    chk1("rm_idle_stall", stall, 1'b0);
    tick();
    @(negedge clk);
    chk("rm_late_rv", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk1("rm_late_stall", stall, 1'b0);
    tick();
    mute = 1'b0;
    lat = 1;
    d_req = 1'b1;
    d_addr = 32'h100;
    d_be = 4'hF;
    dq.push_back(32'h1357_9ADF);
    @(negedge clk);
    chk1("rm_next_gnt", d_gnt, 1'b1);
    tick();
    idle_reqs();
    wait_rv(1'b1, 10, n);
    chk("rm_next_lat", 32'(n), 32'd1);
    tick();
    tick();
    chk("final_drain", 32'(fq.size() + dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
